// File: rtl/vr_responder_if.sv
// Link + pop-side signal bundle for vr_responder.
// 'slave' is the responder's view; 'master' is the stimulus/consumer environment's view.
interface vr_responder_if #(
  parameter int unsigned DATA  = 32,
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned LW = $clog2(DEPTH + 1);

  logic            valid;
  logic [DATA-1:0] data;
  logic            ready;
  logic            out_valid;
  logic [DATA-1:0] out_data;
  logic            out_ready;
  logic [LW-1:0]   level;
  logic            proto_err;

  modport master (
    output valid, data, out_ready,
    input  ready, out_valid, out_data, level, proto_err
  );

  modport slave (
    input  valid, data, out_ready,
    output ready, out_valid, out_data, level, proto_err
  );
endinterface

// File: rtl/vr_responder.sv
// Valid/ready link responder: single-cycle ready pulse, FWFT capture FIFO, pop interface.
// Optional: define VR_RESP_PROTO_CHK_EN to enable the sticky end-of-transfer checker (proto_err).
module vr_responder #(
  parameter int unsigned DATA      = 32,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned READY_DLY = 1
) (
  input logic          clk,
  input logic          reset_n,
  vr_responder_if.slave bus
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned LW = $clog2(DEPTH + 1);

  typedef enum logic [2:0] {IDLE, WAIT, ACK, DRAIN1, DRAIN2} state_e;

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            ready_q;
  logic [DATA-1:0] mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]   level_q, level_d;
  logic            out_valid_q;
  logic            has_space, push, pop;

  assign has_space = (level_q < LW'(DEPTH));

  // State register; ready is registered from the next state so it is high exactly in ACK.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= (state_d == ACK);
    end
  end

  // The IDLE detect cycle counts as the first delay cycle, so ready lands READY_DLY+1 after detect.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.valid) begin
          cnt_d   = 4'(READY_DLY);
          state_d = ((READY_DLY == 0) && has_space) ? ACK : WAIT;
        end
      end
      WAIT: begin
        if (cnt_q > 4'd1) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          cnt_d = '0;
          if (has_space) state_d = ACK;
        end
      end
      ACK:    state_d = DRAIN1;
      DRAIN1: state_d = DRAIN2;
      DRAIN2: if (!bus.valid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    push    = (state_q == ACK);
    pop     = out_valid_q && bus.out_ready;
    level_d = level_q;
    if (push && !pop)      level_d = level_q + LW'(1);
    else if (!push && pop) level_d = level_q - LW'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= bus.data;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q     <= level_d;
      out_valid_q <= (level_d != '0);
    end
  end

  assign bus.ready     = ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = mem_q[rd_ptr_q];
  assign bus.level     = level_q;

`ifdef VR_RESP_PROTO_CHK_EN
  logic proto_err_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                              proto_err_q <= 1'b0;
    else if ((state_q == DRAIN2) && bus.valid) proto_err_q <= 1'b1;
  end

  assign bus.proto_err = proto_err_q;
`else
  assign bus.proto_err = 1'b0;
`endif
endmodule

// File: tb/tb_vr_responder.sv
// Directed bench for vr_responder: DUT A (READY_DLY=1) and DUT B (READY_DLY=0), DEPTH=4.
module tb_vr_responder;
  localparam int unsigned DATA  = 32;
  localparam int unsigned DEPTH = 4;
`ifdef VR_RESP_PROTO_CHK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_cmp = 0;
  int   n_mis = 0;

  vr_responder_if #(.DATA(DATA), .DEPTH(DEPTH)) bus_a ();
  vr_responder_if #(.DATA(DATA), .DEPTH(DEPTH)) bus_b ();

  vr_responder #(.DATA(DATA), .DEPTH(DEPTH), .READY_DLY(1)) u_dut_a (
    .clk(clk), .reset_n(reset_n), .bus(bus_a)
  );
  vr_responder #(.DATA(DATA), .DEPTH(DEPTH), .READY_DLY(0)) u_dut_b (
    .clk(clk), .reset_n(reset_n), .bus(bus_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Returns one cycle after the ready cycle (posedge+1 of t+1).
  task automatic wait_ready(output int waited);
    waited = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus_a.ready) begin
        waited = i;
        break;
      end
      step();
    end
    if (waited < 0) chk("ready_timeout", 0, 1);
    step();
  endtask

  // Compliant master transfer; returns in the cycle the FSM is back in IDLE.
  task automatic send_word(input logic [31:0] d);
    int w;
    bus_a.valid = 1'b1;
    bus_a.data  = d;
    wait_ready(w);
    bus_a.valid = 1'b0;
    step();
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int wt;
    bus_a.valid = 1'b0; bus_a.data = '0; bus_a.out_ready = 1'b0;
    bus_b.valid = 1'b0; bus_b.data = '0; bus_b.out_ready = 1'b0;

    // Reset state
    #2;
    chk("rst_ready",     bus_a.ready, 0);
    chk("rst_out_valid", bus_a.out_valid, 0);
    chk("rst_level",     bus_a.level, 0);
    chk("rst_proto_err", bus_a.proto_err, 0);
    chk("rst_out_data",  bus_a.out_data, 0);
    step();
    reset_n = 1'b1;
    step();

    // T1: single word, READY_DLY=1
    bus_a.valid = 1'b1;
    bus_a.data  = 32'hA5A5_0001;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("t1_ready",     bus_a.ready, (c == 2));
      chk("t1_out_valid", bus_a.out_valid, (c >= 3));
      chk("t1_level",     bus_a.level, (c >= 3) ? 1 : 0);
      if (c == 3) chk("t1_out_data", bus_a.out_data, 32'hA5A5_0001);
      step();
      if (c == 3) bus_a.valid = 1'b0;
    end
    @(negedge clk);
    chk("t1_proto_err", bus_a.proto_err, 0);
    step();
    bus_a.out_ready = 1'b1;
    @(negedge clk);
    chk("t1_pop_valid", bus_a.out_valid, 1);
    step();
    bus_a.out_ready = 1'b0;
    @(negedge clk);
    chk("t1_empty_level", bus_a.level, 0);
    chk("t1_empty_valid", bus_a.out_valid, 0);
    step();

    // T2: fill to DEPTH, 5th word stalls until a pop
    for (int w = 1; w <= 4; w++) send_word(32'h100 + w);
    @(negedge clk);
    chk("t2_full_level", bus_a.level, 4);
    chk("t2_head",       bus_a.out_data, 32'h101);
    step();
    bus_a.valid = 1'b1;
    bus_a.data  = 32'h105;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t2_full_hold", bus_a.ready, 0);
      step();
    end
    bus_a.out_ready = 1'b1;
    @(negedge clk);
    chk("t2_pop_head", bus_a.out_data, 32'h101);
    step();
    bus_a.out_ready = 1'b0;
    wt = -1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus_a.ready) begin
        wt = i;
        break;
      end
      step();
    end
    chk("t2_wake", wt, 1);
    step();
    bus_a.valid = 1'b0;
    step();
    step();
    @(negedge clk);
    chk("t2_refill_level", bus_a.level, 4);
    step();
    bus_a.out_ready = 1'b1;
    for (int k = 2; k <= 5; k++) begin
      @(negedge clk);
      chk("t2_drain_valid", bus_a.out_valid, 1);
      chk("t2_drain_data",  bus_a.out_data, 32'h100 + k);
      step();
    end
    bus_a.out_ready = 1'b0;
    @(negedge clk);
    chk("t2_drained_level", bus_a.level, 0);
    chk("t2_drained_valid", bus_a.out_valid, 0);
    step();

    // T3: push and pop on the same edge at level 2, pointers wrapping
    send_word(32'h201);
    send_word(32'h202);
    @(negedge clk);
    chk("t3_level2", bus_a.level, 2);
    step();
    bus_a.valid = 1'b1;
    bus_a.data  = 32'h203;
    step();
    step();
    bus_a.out_ready = 1'b1;
    @(negedge clk);
    chk("t3_ack_ready", bus_a.ready, 1);
    chk("t3_ack_head",  bus_a.out_data, 32'h201);
    step();
    bus_a.out_ready = 1'b0;
    bus_a.valid     = 1'b0;
    @(negedge clk);
    chk("t3_level_kept", bus_a.level, 2);
    chk("t3_head_adv",   bus_a.out_data, 32'h202);
    step();
    step();
    send_word(32'h204);
    bus_a.out_ready = 1'b1;
    for (int k = 2; k <= 4; k++) begin
      @(negedge clk);
      chk("t3_wrap_data", bus_a.out_data, 32'h200 + k);
      step();
    end
    bus_a.out_ready = 1'b0;
    @(negedge clk);
    chk("t3_wrap_empty", bus_a.level, 0);
    step();

    // T4: valid held 4 cycles past ready
    bus_a.valid = 1'b1;
    bus_a.data  = 32'h301;
    wait_ready(wt);
    for (int h = 1; h <= 4; h++) begin
      @(negedge clk);
      chk("t4_no_reack", bus_a.ready, 0);
      if (h == 2) chk("t4_err_pre",  bus_a.proto_err, 0);
      if (h == 3) chk("t4_err_set",  bus_a.proto_err, EXP_ERR);
      step();
    end
    bus_a.valid = 1'b0;
    step();
    step();
    @(negedge clk);
    chk("t4_one_word",   bus_a.level, 1);
    chk("t4_word",       bus_a.out_data, 32'h301);
    chk("t4_err_sticky", bus_a.proto_err, EXP_ERR);
    step();
    bus_a.out_ready = 1'b1;
    step();
    bus_a.out_ready = 1'b0;
    @(negedge clk);
    chk("t4_empty", bus_a.level, 0);
    step();

    // T5: asynchronous reset during ACK with level 3
    send_word(32'h401);
    send_word(32'h402);
    send_word(32'h403);
    bus_a.valid = 1'b1;
    bus_a.data  = 32'h404;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus_a.ready) break;
      step();
    end
    chk("t5_ack_ready", bus_a.ready, 1);
    chk("t5_pre_level", bus_a.level, 3);
    #1;
    reset_n = 1'b0;
    #1;
    chk("t5_rst_ready",     bus_a.ready, 0);
    chk("t5_rst_out_valid", bus_a.out_valid, 0);
    chk("t5_rst_level",     bus_a.level, 0);
    chk("t5_rst_proto_err", bus_a.proto_err, 0);
    chk("t5_rst_out_data",  bus_a.out_data, 0);
    bus_a.valid = 1'b0;
    #1;
    reset_n = 1'b1;
    step();
    send_word(32'h501);
    @(negedge clk);
    chk("t5_new_level", bus_a.level, 1);
    chk("t5_new_data",  bus_a.out_data, 32'h501);
    step();

    // T6: READY_DLY=0 instance, pop on empty then single word
    bus_b.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t6_pop_empty_level", bus_b.level, 0);
      chk("t6_pop_empty_valid", bus_b.out_valid, 0);
      step();
    end
    bus_b.out_ready = 1'b0;
    bus_b.valid = 1'b1;
    bus_b.data  = 32'h601;
    @(negedge clk);
    chk("t6_ready_c0", bus_b.ready, 0);
    step();
    @(negedge clk);
    chk("t6_ready_c1", bus_b.ready, 1);
    step();
    bus_b.valid = 1'b0;
    @(negedge clk);
    chk("t6_ready_c2", bus_b.ready, 0);
    chk("t6_out_valid", bus_b.out_valid, 1);
    chk("t6_out_data",  bus_b.out_data, 32'h601);
    chk("t6_level",     bus_b.level, 1);
    step();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
